// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver; CLK, RST (async high), RXD in; DATA (held byte), VALID/FERR strobes, BUSY out
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR,
  output logic       BUSY
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t        r_state, w_next;
  logic [1:0]    r_sync, r_live;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_shift, w_shift, r_data, w_data;
  logic          r_valid, w_valid, r_ferr, w_ferr, w_rx;
  assign w_rx  = r_sync[1];
  assign DATA  = r_data;
  assign VALID = r_valid;
  assign FERR  = r_ferr;
  assign BUSY  = r_state inside {S_START, S_DATA, S_STOP};
  // r_live marks when rx_s holds a real line sample rather than the reset value,
  // so a line held low across reset release is not mistaken for idle.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_sync  <= 2'b11;
      r_live  <= 2'b00;
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], RXD};
      r_live  <= {r_live[0], 1'b1};
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_cnt  = '0;
        w_next = (w_rx && r_live[1]) ? S_IDLE : S_WAIT;
      end
      S_IDLE: begin
        w_cnt  = '0;
        w_next = w_rx ? S_IDLE : S_START;
      end
      S_START:
        if (r_cnt == HALF_LAST) begin
          w_cnt  = '0;
          w_idx  = '0;
          w_next = w_rx ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (r_cnt == BIT_LAST) begin
          w_cnt   = '0;
          w_shift = {w_rx, r_shift[7:1]};
          w_idx   = r_idx + 1'b1;
          w_next  = (r_idx == 3'd7) ? S_STOP : S_DATA;
        end
      S_STOP:
        if (r_cnt == BIT_LAST) begin
          w_cnt   = '0;
          w_data  = w_rx ? r_shift : r_data;
          w_valid = w_rx;
          w_ferr  = !w_rx;
          w_next  = w_rx ? S_IDLE : S_WAIT;
        end
      default: w_next = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed and random frames checked against a byte scoreboard
module tb_uart_rx_byte;
  localparam int CPB = 8;
  logic       CLK = 1'b0, RST = 1'b1, RXD = 1'b1;
  logic [7:0] DATA;
  logic       VALID, FERR, BUSY;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, valid_cnt = 0, ferr_cnt = 0, busy_cnt = 0;
  int both_bad = 0, dbl_bad = 0, hold_bad = 0;
  logic [7:0] got_q[$], exp_q[$];
  int vcyc_q[$];
  int rd_idx = 0;
  logic [7:0] pdata = 8'h00;
  logic pv = 1'b0, pf = 1'b0;
  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD),
    .DATA(DATA), .VALID(VALID), .FERR(FERR), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (VALID) begin
      got_q.push_back(DATA);
      vcyc_q.push_back(cyc);
      valid_cnt++;
    end
    if (FERR) ferr_cnt++;
    if (BUSY) busy_cnt++;
    if (VALID && FERR) both_bad++;
    if ((VALID && pv) || (FERR && pf)) dbl_bad++;
    if (!RST && !VALID && DATA !== pdata) hold_bad++;
    pdata = DATA;
    pv = VALID;
    pf = FERR;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    RXD = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      cycles(CPB);
    end
    RXD = stop;
    cycles(CPB);
  endtask
  task automatic send_ok(input logic [7:0] b, output int t0);
    exp_q.push_back(b);
    send(b, 1'b1, t0);
  endtask
  task automatic pop_chk(input string tag, output int vc);
    logic [7:0] e;
    logic [31:0] o;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    o = 32'hDEAD_BEEF;
    vc = -1;
    if (rd_idx < got_q.size()) begin
      o = {24'h0, got_q[rd_idx]};
      vc = vcyc_q[rd_idx];
      rd_idx++;
    end
    chk(tag, o, {24'h0, e});
  endtask
  initial begin
    int t0, t1, vc0, vc1, v0, f0, b0;
    logic [7:0] r;
    #1;
    chk("reset_data", DATA, 8'h00);
    chk("reset_valid", VALID, 1'b0);
    chk("reset_ferr", FERR, 1'b0);
    chk("reset_busy", BUSY, 1'b0);
    cycles(3);
    RST = 1'b0;
    cycles(10);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_ok(8'hA5, t0);
    cycles(1);
    pop_chk("a5_data", vc0);
    chk("a5_latency", vc0 - t0, 79);
    chk("a5_valid_cnt", valid_cnt - v0, 1);
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk("a5_busy_after", BUSY, 1'b0);
    chk("a5_valid_low", VALID, 1'b0);
    cycles(8);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_ok(8'h00, t0);
    send_ok(8'hFF, t1);
    cycles(2);
    pop_chk("b2b_first", vc0);
    pop_chk("b2b_second", vc1);
    chk("b2b_spacing", vc1 - vc0, 80);
    chk("b2b_ferr", ferr_cnt - f0, 0);
    chk("b2b_valid_cnt", valid_cnt - v0, 2);
    cycles(8);
    send_ok(8'h5A, t0);
    cycles(4);
    pop_chk("pre_glitch", vc0);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    b0 = busy_cnt;
    RXD = 1'b0;
    cycles(2);
    RXD = 1'b1;
    cycles(12);
    chk("glitch_busy_cycles", busy_cnt - b0, 4);
    chk("glitch_busy_low", BUSY, 1'b0);
    chk("glitch_no_valid", valid_cnt - v0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_data", DATA, 8'h5A);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send(8'h3C, 1'b0, t0);
    b0 = busy_cnt;
    cycles(30);
    chk("ferr_pulse", ferr_cnt - f0, 1);
    chk("ferr_no_valid", valid_cnt - v0, 0);
    chk("ferr_data_kept", DATA, 8'h5A);
    chk("ferr_low_no_start", busy_cnt - b0, 0);
    RXD = 1'b1;
    cycles(16);
    send_ok(8'h81, t0);
    cycles(2);
    pop_chk("after_ferr", vc0);
    chk("after_ferr_cnt", ferr_cnt - f0, 1);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    RXD = 1'b0;
    cycles(CPB);
    r = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      RXD = r[i];
      cycles(CPB);
    end
    RST = 1'b1;
    #1;
    chk("rst_mid_data", DATA, 8'h00);
    chk("rst_mid_busy", BUSY, 1'b0);
    RXD = 1'b0;
    cycles(3);
    RST = 1'b0;
    cycles(100);
    chk("rst_low_no_busy", BUSY, 1'b0);
    RXD = 1'b1;
    cycles(16);
    send_ok(8'h42, t0);
    cycles(2);
    pop_chk("rst_then_42", vc0);
    chk("rst_valid_cnt", valid_cnt - v0, 1);
    chk("rst_no_ferr", ferr_cnt - f0, 0);
    for (int k = 0; k < 5; k++) begin
      r = 8'($urandom_range(0, 255));
      send_ok(r, t0);
      cycles($urandom_range(0, 12));
      pop_chk("random_frame", vc0);
    end
    cycles(4);
    chk("hold_violations", hold_bad, 0);
    chk("valid_ferr_overlap", both_bad, 0);
    chk("strobe_width", dbl_bad, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("no_extra_valid", got_q.size() - rd_idx, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
